wb_stage: RTL

Writeback stage of the nano_rv32i pipeline, directly upstream of the register file write port.
- Accepts retiring instructions from the MEM stage and waits for data-memory load responses.
- Aligns and sign- or zero-extends load data and selects the writeback source.
- Drives the regfile's reg_write/rd/write_data inputs from registered outputs.
- Counts retired instructions.

---
 rtl/wb_stage.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/wb_stage.sv
// Purpose : writeback stage of nano_rv32i. It retires MEM-stage instructions, waits for
//           load data, aligns and extends that data, and drives the regfile write port
//           from registered outputs. It also keeps a 64-bit retired-instruction counter.
// Latency : a non-load writes back 1 cycle after accept. A load writes back 1 cycle after
//           its dmem_rvalid_i beat.
// Backpr. : ready_o is low while a load is outstanding (WAIT_LOAD). No buffering is done
//           beyond the single pending load.
// Ports   : clk_i/rst_i (sync, active-high); valid_i/ready_o MEM handshake; rd_i,
//           reg_write_i, wb_sel_i, alu_result_i, pc_plus4_i, load_funct3_i, addr_lo_i
//           instruction fields; dmem_rvalid_i/dmem_rdata_i load response; reg_write_o,
//           rd_o, write_data_o regfile port; retire_o, load_err_o pulses; instret_o count.
module wb_stage #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [REG_ADDR_W-1:0] rd_i,
    input  logic                  reg_write_i,
    input  logic [1:0]            wb_sel_i,
    input  logic [XLEN-1:0]       alu_result_i,
    input  logic [XLEN-1:0]       pc_plus4_i,
    input  logic [2:0]            load_funct3_i,
    input  logic [1:0]            addr_lo_i,
    input  logic                  dmem_rvalid_i,
    input  logic [XLEN-1:0]       dmem_rdata_i,
    output logic                  reg_write_o,
    output logic [REG_ADDR_W-1:0] rd_o,
    output logic [XLEN-1:0]       write_data_o,
    output logic                  retire_o,
    output logic                  load_err_o,
    output logic [63:0]           instret_o
);

    typedef enum logic {
        IDLE      = 1'b0,
        WAIT_LOAD = 1'b1
    } state_t;

    localparam logic [1:0] WB_LOAD = 2'b01;
    localparam logic [1:0] WB_PC4  = 2'b10;

    state_t                  state;
    logic [REG_ADDR_W-1:0]   pend_rd;
    logic                    pend_we;
    logic [2:0]              pend_f3;
    logic [1:0]              pend_lo;

    logic                    load_illegal;
    logic [7:0]              ld_byte;
    logic [15:0]             ld_half;
    logic [XLEN-1:0]         ld_data;
    logic [XLEN-1:0]         nonload_data;

    assign ready_o = (state == IDLE);

    // The legality check runs at accept, on the live inputs.
    always_comb begin
        load_illegal = 1'b0;
        case (load_funct3_i)
            3'b000, 3'b100: load_illegal = 1'b0;
            3'b001, 3'b101: load_illegal = addr_lo_i[0];
            3'b010:         load_illegal = (addr_lo_i != 2'b00);
            default:        load_illegal = 1'b1;
        endcase
    end

    // Extraction uses the latched offset and funct3, applied to the response word.
    always_comb begin
        ld_byte = 8'h00;
        case (pend_lo)
            2'd0:    ld_byte = dmem_rdata_i[7:0];
            2'd1:    ld_byte = dmem_rdata_i[15:8];
            2'd2:    ld_byte = dmem_rdata_i[23:16];
            default: ld_byte = dmem_rdata_i[31:24];
        endcase
        ld_half = pend_lo[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
        case (pend_f3)
            3'b000:  ld_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
            3'b001:  ld_data = {{(XLEN-16){ld_half[15]}}, ld_half};
            3'b100:  ld_data = {{(XLEN-8){1'b0}}, ld_byte};
            3'b101:  ld_data = {{(XLEN-16){1'b0}}, ld_half};
            default: ld_data = dmem_rdata_i;
        endcase
    end

    // wb_sel 11 falls through to the ALU result.
    assign nonload_data = (wb_sel_i == WB_PC4) ? pc_plus4_i : alu_result_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= IDLE;
            reg_write_o  <= 1'b0;
            rd_o         <= '0;
            write_data_o <= '0;
            retire_o     <= 1'b0;
            load_err_o   <= 1'b0;
            instret_o    <= 64'd0;
            pend_rd      <= '0;
            pend_we      <= 1'b0;
            pend_f3      <= 3'b000;
            pend_lo      <= 2'b00;
        end else begin
            // Pulses default low. rd_o and write_data_o hold unless something retires.
            reg_write_o <= 1'b0;
            retire_o    <= 1'b0;
            load_err_o  <= 1'b0;
            case (state)
                IDLE: begin
                    if (valid_i) begin
                        if (wb_sel_i == WB_LOAD) begin
                            if (load_illegal) begin
                                load_err_o <= 1'b1;
                            end else begin
                                state   <= WAIT_LOAD;
                                pend_rd <= rd_i;
                                pend_we <= reg_write_i;
                                pend_f3 <= load_funct3_i;
                                pend_lo <= addr_lo_i;
                            end
                        end else begin
                            reg_write_o  <= reg_write_i && (rd_i != '0);
                            rd_o         <= rd_i;
                            write_data_o <= nonload_data;
                            retire_o     <= 1'b1;
                            instret_o    <= instret_o + 64'd1;
                        end
                    end
                end
                WAIT_LOAD: begin
                    if (dmem_rvalid_i) begin
                        state        <= IDLE;
                        reg_write_o  <= pend_we && (pend_rd != '0);
                        rd_o         <= pend_rd;
                        write_data_o <= ld_data;
                        retire_o     <= 1'b1;
                        instret_o    <= instret_o + 64'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
